fp_share_arbiter: RTL

//  Shares one fixed-latency pipelined floating-point unit (the `floating` datapath) between two requesters.

---
 rtl/fp_share_arbiter_pkg.sv | 23 ++
 rtl/fp_tag_pipe.sv | 34 +++
 rtl/fp_share_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fp_share_arbiter_pkg.sv
// Shared definitions for the floating-point unit share arbiter.
//   - FPU opcode encodings and the quiet-NaN returned for reserved ops
//   - tag_t: per-operation bookkeeping carried alongside the FPU pipeline
package fp_share_arbiter_pkg;

  localparam logic [1:0] FP_OP_ADD  = 2'b00;
  localparam logic [1:0] FP_OP_SUB  = 2'b01;
  localparam logic [1:0] FP_OP_MUL  = 2'b10;
  localparam logic [1:0] FP_OP_RSVD = 2'b11;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // One tag per accepted operation: which requester owns it and whether it
  // bypassed the FPU because its opcode is reserved.
  typedef struct packed {
    logic valid;
    logic id;
    logic rsvd;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/fp_tag_pipe.sv
// Fixed-depth, non-stalling shift register for operation tags.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-high; clears every stage
//   head   word entering stage 0 each cycle
//   tail   word leaving the last stage (DEPTH cycles after entry)
module fp_tag_pipe #(
  parameter int DEPTH = 5,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] head,
  output logic [W-1:0] tail
);

  logic [W-1:0] stage [DEPTH];

  // NOTE: every stage is reset (unusual for a storage array) because the
  // valid bits must be cleared to drop in-flight operations on reset.
  // NOTE: non-blocking assignments make all stages shift on the same edge;
  // blocking ones would ripple a word through several stages at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tail = stage[DEPTH-1];

endmodule

// File: rtl/fp_share_arbiter.sv
// Shares one fixed-latency pipelined FPU between two requesters.
// Round-robin grant accepts at most one operation per cycle, a registered
// issue stage drives the FPU, and a tag pipeline of matching depth routes
// each result back to its owner in acceptance order.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req0_valid/ready/op/a/b     requester 0 operation handshake
//   rsp0_valid/data             requester 0 result pulse (no backpressure)
//   req1_*, rsp1_*              same for requester 1
//   fpu_valid/op/a/b            FPU issue port
//   fpu_result                  FPU output, FPU_LATENCY cycles after issue
//   debug                       {accept_cnt1, accept_cnt0}
module fp_share_arbiter
  import fp_share_arbiter_pkg::*;
#(
  parameter int FPU_LATENCY = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              fpu_valid,
  output logic [1:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic [DATA_W-1:0] fpu_result,
  output logic [31:0]       debug
);

  // 1 means requester 1 won the most recent accept, so requester 0 wins the
  // next tie; reset value makes requester 0 win the first tie.
  logic        last_grant;
  logic [15:0] accept_cnt0;
  logic [15:0] accept_cnt1;

  logic              accept;
  logic              accept_id;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_rsvd;
  tag_t              tag_new;
  tag_t              tag_done;

  assign req0_ready = !reset && req0_valid && (!req1_valid ||  last_grant);
  assign req1_ready = !reset && req1_valid && (!req0_valid || !last_grant);

  assign accept    = req0_ready || req1_ready;
  assign accept_id = req1_ready;

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (accept_id) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  assign sel_rsvd = (sel_op == FP_OP_RSVD);

  // Arbitration state, issue registers and accept counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= 1'b1;
      fpu_valid   <= 1'b0;
      fpu_op      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      accept_cnt0 <= '0;
      accept_cnt1 <= '0;
    end else begin
      fpu_valid <= accept && !sel_rsvd;
      if (accept) begin
        last_grant <= accept_id;
        if (accept_id) accept_cnt1 <= accept_cnt1 + 16'd1;
        else           accept_cnt0 <= accept_cnt0 + 16'd1;
      end
      // Operands hold their last issued value when nothing is issued.
      if (accept && !sel_rsvd) begin
        fpu_op <= sel_op;
        fpu_a  <= sel_a;
        fpu_b  <= sel_b;
      end
    end
  end

  assign tag_new = '{valid: accept, id: accept_id, rsvd: sel_rsvd};

  // One extra stage covers the registered issue cycle ahead of the FPU, so
  // the tag emerges in the same cycle as its result on fpu_result.
  fp_tag_pipe #(
    .DEPTH (FPU_LATENCY + 1),
    .W     (TAG_W)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .head  (tag_new),
    .tail  (tag_done)
  );

  // Response registers; data holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= tag_done.valid && !tag_done.id;
      rsp1_valid <= tag_done.valid &&  tag_done.id;
      if (tag_done.valid && !tag_done.id)
        rsp0_data <= tag_done.rsvd ? DATA_W'(FP_QNAN) : fpu_result;
      if (tag_done.valid && tag_done.id)
        rsp1_data <= tag_done.rsvd ? DATA_W'(FP_QNAN) : fpu_result;
    end
  end

  assign debug = {accept_cnt1, accept_cnt0};

endmodule
